apb_ecc_initiator: RTL and testbench

APB_ECC_INITIATOR -- requirements
Module: apb_ecc_initiator

---
 rtl/apb_ecc_initiator_if.sv | 40 ++++
 rtl/apb_ecc_initiator.sv | 131 +++++++++++++
 tb/tb_apb_ecc_initiator.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_ecc_initiator_if.sv
// apb_ecc_initiator_if -- request/response and APB requester signal bundle.
//
// Signals:
//   req_valid/req_ready/req_write/req_addr/req_wdata : request queue push side
//   xfer_done/rsp_rdata/busy                         : completion and status
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA          : APB requester (no PREADY/PSLVERR)
// Modports:
//   master : view of the initiator itself
//   slave  : view of whatever surrounds it (request source and APB completer)
interface apb_ecc_initiator_if #(
    parameter int unsigned AMBA_ADDR_WIDTH = 20,
    parameter int unsigned AMBA_WORD       = 32
);
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_write;
    logic [AMBA_ADDR_WIDTH-1:0] req_addr;
    logic [AMBA_WORD-1:0]       req_wdata;
    logic                       xfer_done;
    logic [AMBA_WORD-1:0]       rsp_rdata;
    logic                       busy;
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic [AMBA_WORD-1:0]       PWDATA;
    logic [AMBA_WORD-1:0]       PRDATA;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA,
        output req_ready, xfer_done, rsp_rdata, busy,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA,
        input  req_ready, xfer_done, rsp_rdata, busy,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_ecc_initiator.sv
// apb_ecc_initiator -- queued APB requester.
//
// Requests are pushed into a FIFO_DEPTH-entry queue and issued on APB in strict
// order as SETUP/ACCESS pairs. A read's PRDATA is captured into rsp_rdata and every
// completed transfer pulses xfer_done for one cycle.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, aborts any transfer in flight
//   bus  : apb_ecc_initiator_if.master (request, status and APB signals)
//
// Configuration macro:
//   APB_INIT_BACK2BACK_EN : when defined, ACCESS goes straight to SETUP if more work
//                           is queued; otherwise one idle cycle separates transfers.
module apb_ecc_initiator #(
    parameter int unsigned AMBA_ADDR_WIDTH = 20,
    parameter int unsigned AMBA_WORD       = 32,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input logic                 clk,
    input logic                 rst,
    apb_ecc_initiator_if.master bus
);
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned EntryW = 1 + AMBA_ADDR_WIDTH + AMBA_WORD;
    localparam logic [PtrW:0] PtrOne = {{PtrW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e                     state_q, state_d;
    logic [EntryW-1:0]          fifo_q [FIFO_DEPTH];
    // Extra MSB on each pointer separates full from empty.
    logic [PtrW:0]              wr_ptr_q, rd_ptr_q;
    logic                       empty, full, push, pop;
    logic [EntryW-1:0]          head;
    logic                       pwrite_q, pwrite_d;
    logic [AMBA_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [AMBA_WORD-1:0]       pwdata_q, pwdata_d;
    logic [AMBA_WORD-1:0]       rdata_q, rdata_d;
    logic                       done_q, done_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    // Fullness is judged before any same-edge pop, so a pop never frees a slot early.
    assign push  = bus.req_valid && !full;
    assign head  = fifo_q[rd_ptr_q[PtrW-1:0]];

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Queue state is the one before this edge's push: no bypass.
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = StSetup;
                end
            end
            StSetup: state_d = StAccess;
            StAccess: begin
                done_d = 1'b1;
                if (!pwrite_q) begin
                    rdata_d = bus.PRDATA;
                end
`ifdef APB_INIT_BACK2BACK_EN
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = StSetup;
                end else begin
                    state_d = StIdle;
                end
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
        if (pop) begin
            {pwrite_d, paddr_d, pwdata_d} = head;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
        end
    end

    // Queue storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_q[wr_ptr_q[PtrW-1:0]] <= {bus.req_write, bus.req_addr, bus.req_wdata};
        end
    end

    assign bus.req_ready = !full && !rst;
    assign bus.busy      = (state_q != StIdle) || !empty;
    assign bus.PSEL      = (state_q != StIdle);
    assign bus.PENABLE   = (state_q == StAccess);
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.xfer_done = done_q;
    assign bus.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_apb_ecc_initiator.sv
// tb_apb_ecc_initiator -- self-checking bench for apb_ecc_initiator.
//
// A transaction-level model (request queue plus the transfer in flight) predicts
// every output on every cycle; directed scenarios add literal expectations.
// Honours APB_INIT_BACK2BACK_EN the same way the design does.
module tb_apb_ecc_initiator;
    localparam int unsigned AW    = 20;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
`ifdef APB_INIT_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_ecc_initiator_if #(.AMBA_ADDR_WIDTH(AW), .AMBA_WORD(DW)) bus ();

    apb_ecc_initiator #(
        .AMBA_ADDR_WIDTH(AW),
        .AMBA_WORD      (DW),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[$];
    ent_t          m_cur;
    int            m_age;   // cycles the current transfer has been on the bus; -1 = none
    bit            m_done;
    logic [DW-1:0] m_rdata;
    bit            m_valid = 1'b0;

    always @(posedge clk) begin
        bit   can_push;
        bit   start;
        ent_t req;
        if (rst) begin
            mq.delete();
            m_cur   = '0;
            m_age   = -1;
            m_done  = 1'b0;
            m_rdata = '0;
        end else begin
            can_push = bus.req_valid && (mq.size() < DEPTH);
            req      = '{w: bus.req_write, a: bus.req_addr, d: bus.req_wdata};
            start    = 1'b0;
            m_done   = 1'b0;
            if (m_age == 0) begin
                m_age = 1;
            end else if (m_age == 1) begin
                m_done = 1'b1;
                if (!m_cur.w) m_rdata = bus.PRDATA;
                m_age = -1;
                if (B2B && mq.size() > 0) start = 1'b1;
            end else if (mq.size() > 0) begin
                start = 1'b1;
            end
            if (start) begin
                m_cur = mq.pop_front();
                m_age = 0;
            end
            if (can_push) mq.push_back(req);
        end
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_psel",    bus.PSEL,      m_age >= 0);
            chk("m_penable", bus.PENABLE,   m_age == 1);
            chk("m_paddr",   bus.PADDR,     m_cur.a);
            chk("m_pwdata",  bus.PWDATA,    m_cur.d);
            chk("m_pwrite",  bus.PWRITE,    m_cur.w);
            chk("m_done",    bus.xfer_done, m_done);
            chk("m_rdata",   bus.rsp_rdata, m_rdata);
            chk("m_busy",    bus.busy,      (m_age >= 0) || (mq.size() > 0));
            chk("m_ready",   bus.req_ready, !rst && (mq.size() < DEPTH));
        end
    end

    // ---------------- monitors for directed scenarios ----------------
    logic [AW-1:0] seen_addr[$];
    bit win_on = 1'b0;
    int win_idx, psel_cnt, psel_first, psel_last, run, max_run;

    always @(negedge clk) begin
        if (bus.PSEL && bus.PENABLE) seen_addr.push_back(bus.PADDR);
        if (win_on) begin
            if (bus.PSEL) begin
                if (psel_cnt == 0) psel_first = win_idx;
                psel_last = win_idx;
                psel_cnt++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            win_idx++;
        end
    end

    task automatic win_clear();
        win_idx  = 0;
        psel_cnt = 0;
        psel_first = 0;
        psel_last  = 0;
        run      = 0;
        max_run  = 0;
    endtask

    // ---------------- stimulus helpers ----------------
    int stalls = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        bit acc;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        do begin
            acc = bus.req_ready;
            if (!acc) stalls++;
            step();
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("push_timeout", 0, 1);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 100) begin
            step();
            n++;
        end
        chk("wait_idle", bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.PRDATA    = '0;
        win_clear();

        // Reset values
        rst = 1'b1;
        step();
        step();
        chk("rst_psel",    bus.PSEL, 0);
        chk("rst_penable", bus.PENABLE, 0);
        chk("rst_paddr",   bus.PADDR, 0);
        chk("rst_pwdata",  bus.PWDATA, 0);
        chk("rst_pwrite",  bus.PWRITE, 0);
        chk("rst_rdata",   bus.rsp_rdata, 0);
        chk("rst_done",    bus.xfer_done, 0);
        chk("rst_busy",    bus.busy, 0);
        chk("rst_ready",   bus.req_ready, 0);
        rst = 1'b0;
        step();
        chk("ready_after_rst", bus.req_ready, 1);

        // Single write and its latency
        push(1'b1, 20'h00004, 32'hA5A5_0001);
        chk("wr_e0_psel", bus.PSEL, 0);
        chk("wr_e0_busy", bus.busy, 1);
        step();
        chk("wr_setup_psel",    bus.PSEL, 1);
        chk("wr_setup_penable", bus.PENABLE, 0);
        chk("wr_setup_paddr",   bus.PADDR, 20'h00004);
        chk("wr_setup_pwdata",  bus.PWDATA, 32'hA5A5_0001);
        chk("wr_setup_pwrite",  bus.PWRITE, 1);
        step();
        chk("wr_access_psel",    bus.PSEL, 1);
        chk("wr_access_penable", bus.PENABLE, 1);
        chk("wr_access_paddr",   bus.PADDR, 20'h00004);
        chk("wr_access_pwdata",  bus.PWDATA, 32'hA5A5_0001);
        step();
        chk("wr_done_pulse", bus.xfer_done, 1);
        chk("wr_done_psel",  bus.PSEL, 0);
        chk("wr_rdata_zero", bus.rsp_rdata, 0);
        step();
        chk("wr_done_low",   bus.xfer_done, 0);

        // Read captures PRDATA
        bus.PRDATA = 32'h0000_00F3;
        push(1'b0, 20'h0000C, 32'h0);
        step();
        step();
        chk("rd_access_pwrite", bus.PWRITE, 0);
        bus.PRDATA = 32'h0000_00F3;
        step();
        bus.PRDATA = 32'hDEAD_BEEF;
        chk("rd_done_pulse", bus.xfer_done, 1);
        chk("rd_rdata",      bus.rsp_rdata, 32'h0000_00F3);

        // rsp_rdata holds across a write
        push(1'b1, 20'h00010, 32'h1234_5678);
        wait_idle();
        repeat (2) step();
        chk("rd_hold_after_wr", bus.rsp_rdata, 32'h0000_00F3);

        // Queue fills; issue order preserved
        seen_addr.delete();
        stalls = 0;
        for (int i = 0; i < 8; i++) push(1'b1, AW'(i * 4), DW'(32'hC0DE_0000 + i));
        wait_idle();
        chk("full_stalled", stalls > 0, 1);
        chk("full_count",   seen_addr.size(), 8);
        for (int i = 0; i < 4; i++) begin
            if (seen_addr.size() > i) chk("full_order", seen_addr[i], AW'(i * 4));
        end

        // Three queued writes: PSEL pattern
        win_clear();
        win_on = 1'b1;
        for (int i = 0; i < 3; i++) push(1'b1, AW'(20'h100 + i * 4), DW'(i));
        wait_idle();
        step();
        win_on = 1'b0;
        chk("b2b_psel_cycles", psel_cnt, 6);
        if (B2B) begin
            chk("b2b_run",  max_run, 6);
        end else begin
            chk("gap_span", psel_last - psel_first + 1, 8);
            chk("gap_run",  max_run, 2);
        end

        // Reset during ACCESS of a read with two entries queued
        push(1'b0, 20'h00020, 32'h0);
        push(1'b1, 20'h00024, 32'h24);
        push(1'b1, 20'h00028, 32'h28);
        begin
            int n;
            n = 0;
            while (!(bus.PSEL && bus.PENABLE) && n < 20) begin
                step();
                n++;
            end
        end
        chk("abort_in_access", bus.PENABLE, 1);
        chk("abort_addr",      bus.PADDR, 20'h00020);
        bus.PRDATA = 32'h7777_7777;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_psel",    bus.PSEL, 0);
        chk("abort_penable", bus.PENABLE, 0);
        chk("abort_done",    bus.xfer_done, 0);
        chk("abort_rdata",   bus.rsp_rdata, 0);
        chk("abort_busy",    bus.busy, 0);
        win_clear();
        win_on = 1'b1;
        repeat (6) step();
        win_on = 1'b0;
        chk("abort_no_more", psel_cnt, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(0, 79) == 0);
            bus.req_valid = ($urandom_range(0, 9) < 7);
            bus.req_write = $urandom_range(0, 1);
            bus.req_addr  = AW'($urandom);
            bus.req_wdata = $urandom;
            bus.PRDATA    = $urandom;
            step();
        end
        rst = 1'b0;
        bus.req_valid = 1'b0;
        wait_idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
